// File: rtl/async_fifo_read_arb.sv
// async_fifo_read_arb
//   Round-robin read arbiter over NUM_CH FIFO read ports. It feeds a
//   SKID_DEPTH-entry output FIFO that carries each word together with its
//   source channel.
//   read_clk / read_reset   : single clock, synchronous active-high reset
//   read_fifo_pop  (out)    : one-hot pop request. Data returns a cycle later.
//   read_data      (in)     : channel i at [i*W +: W]
//   read_fifo_empty(in)     : per-channel empty flags
//   ch_enable      (in)     : per-channel arbitration enables
//   out_valid/out_ready     : output handshake
//   out_data/out_ch         : head word and its source channel
module async_fifo_read_arb #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int NUM_CH          = 4,
  parameter int SKID_DEPTH      = 3,
  localparam int CH_W           = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              read_clk,
  input  logic                              read_reset,
  output logic [NUM_CH-1:0]                 read_fifo_pop,
  input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0] read_data,
  input  logic [NUM_CH-1:0]                 read_fifo_empty,
  input  logic [NUM_CH-1:0]                 ch_enable,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [FIFO_DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]                   out_ch
);

  localparam int PTR_W = ($clog2(SKID_DEPTH) > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned NCH = NUM_CH;

  logic [CNT_W-1:0]           count_q, count_d;
  logic                       pend_q, pend_d;
  logic [CH_W-1:0]            pend_ch_q, pend_ch_d;
  logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [FIFO_DATA_WIDTH-1:0] data_mem_q [SKID_DEPTH];
  logic [FIFO_DATA_WIDTH-1:0] data_mem_d [SKID_DEPTH];
  logic [CH_W-1:0]            ch_mem_q   [SKID_DEPTH];
  logic [CH_W-1:0]            ch_mem_d   [SKID_DEPTH];

  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [CH_W-1:0]   gnt;
  logic              credit_ok;
  logic              pop;
  logic              deq;
  int unsigned       idx;

  // Grant search: the first eligible channel at or after rr_ptr, cyclically.
  always_comb begin
    eligible = ~read_fifo_empty & ch_enable;
    found    = 1'b0;
    gnt      = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NCH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
  end

  // The word already in flight (pend) reserves a slot. This makes a capture
  // into a full buffer impossible without looking at out_ready.
  always_comb begin
    credit_ok = (int'(count_q) + int'(pend_q)) < SKID_DEPTH;
    pop       = found && credit_ok && !read_reset;
    read_fifo_pop = '0;
    if (pop) read_fifo_pop[gnt] = 1'b1;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_ch    = ch_mem_q[rd_ptr_q];
  assign deq       = out_valid && out_ready;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    pend_d     = pop;
    pend_ch_d  = pend_ch_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_mem_d = data_mem_q;
    ch_mem_d   = ch_mem_q;
    count_d    = count_q + CNT_W'(pend_q) - CNT_W'(deq);

    if (pop) begin
      rr_ptr_d  = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
      pend_ch_d = gnt;
    end

    if (pend_q) begin
      data_mem_d[wr_ptr_q] = read_data[int'(pend_ch_q)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
      ch_mem_d[wr_ptr_q]   = pend_ch_q;
      wr_ptr_d = (wr_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_ch_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        ch_mem_q[i]   <= '0;
      end
    end else begin
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_mem_q <= data_mem_d;
      ch_mem_q   <= ch_mem_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_read_arb.sv
// Testbench for async_fifo_read_arb (NUM_CH=4, W=32, SKID_DEPTH=3).
// Upstream FIFOs are modelled as simple queues with registered read data.
module tb_async_fifo_read_arb;

  logic         read_clk;
  logic         read_reset;
  logic [3:0]   read_fifo_pop;
  logic [127:0] read_data;
  logic [3:0]   read_fifo_empty;
  logic [3:0]   ch_enable;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;

  async_fifo_read_arb #(
    .FIFO_DATA_WIDTH(32),
    .NUM_CH(4),
    .SKID_DEPTH(3)
  ) dut (
    .read_clk(read_clk),
    .read_reset(read_reset),
    .read_fifo_pop(read_fifo_pop),
    .read_data(read_data),
    .read_fifo_empty(read_fifo_empty),
    .ch_enable(ch_enable),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ch(out_ch)
  );

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  // Upstream FIFO model
  logic [31:0] fmem [4][64];
  int          wr [4];
  int          rd [4] = '{default: 0};
  logic [31:0] rdata [4] = '{default: 32'h0};
  logic        bad_pop = 1'b0;

  always_comb begin
    for (int i = 0; i < 4; i++) read_fifo_empty[i] = (rd[i] == wr[i]);
  end
  assign read_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

  always @(posedge read_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (read_fifo_pop[i]) begin
        if (read_fifo_empty[i] || !ch_enable[i]) bad_pop <= 1'b1;
        rdata[i] <= fmem[i][rd[i] % 64];
        rd[i]    <= rd[i] + 1;
      end
    end
  end

  task automatic clear_ch(input int ch);
    wr[ch] = rd[ch];
  endtask

  task automatic load_ch(input int ch, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      fmem[ch][wr[ch] % 64] = base + 32'(k);
      wr[ch] = wr[ch] + 1;
    end
  endtask

  // Checking
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input logic [3:0] en, input logic rdy, input logic rst,
                     input logic [3:0] epop, input logic ev,
                     input logic [31:0] edata, input logic [1:0] ech,
                     input string tag);
    ch_enable  = en;
    out_ready  = rdy;
    read_reset = rst;
    @(negedge read_clk);
    chk({tag, "_pop"}, 32'(read_fifo_pop), 32'(epop));
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({tag, "_data"}, out_data, edata);
      chk({tag, "_ch"}, 32'(out_ch), 32'(ech));
    end
    @(posedge read_clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic        rdy;
    logic        rst;
    logic [3:0]  pop;
    logic        v;
    logic [31:0] data;
    logic [1:0]  ch;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // reset, round-robin over all channels, then mask 4'b1010 until ch1/ch3 run dry
    tbl[0]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,         2'd0};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 32'h0,         2'd0};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b0, 32'h0,         2'd0};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 32'hD000_0000, 2'd0};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0010, 2'd1};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 32'hD000_0020, 2'd2};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 32'hD000_0030, 2'd3};
    tbl[8]  = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 32'hD000_0001, 2'd0};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0011, 2'd1};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 32'hD000_0021, 2'd2};
    tbl[11] = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 32'hD000_0031, 2'd3};
    tbl[12] = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 32'hD000_0002, 2'd0};
    tbl[13] = '{4'hA, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0012, 2'd1};
    tbl[14] = '{4'hA, 1'b1, 1'b0, 4'h2, 1'b1, 32'hD000_0022, 2'd2};
    tbl[15] = '{4'hA, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0032, 2'd3};
    tbl[16] = '{4'hA, 1'b1, 1'b0, 4'h2, 1'b1, 32'hD000_0013, 2'd1};
    tbl[17] = '{4'hA, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0033, 2'd3};
    tbl[18] = '{4'hA, 1'b1, 1'b0, 4'h2, 1'b1, 32'hD000_0014, 2'd1};
    tbl[19] = '{4'hA, 1'b1, 1'b0, 4'h8, 1'b1, 32'hD000_0034, 2'd3};
    tbl[20] = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 32'hD000_0015, 2'd1};
    tbl[21] = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 32'hD000_0035, 2'd3};
    tbl[22] = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0,         2'd0};

    for (int i = 0; i < 4; i++) wr[i] = 0;
    for (int i = 0; i < 4; i++) load_ch(i, 6, 32'hD000_0000 + 32'(i * 16));
    read_reset = 1'b1;
    ch_enable  = 4'hF;
    out_ready  = 1'b1;
    @(posedge read_clk);
    #1;

    for (int i = 0; i < 23; i++)
      cyc(tbl[i].en, tbl[i].rdy, tbl[i].rst, tbl[i].pop, tbl[i].v,
          tbl[i].data, tbl[i].ch, $sformatf("row%0d", i));

    // single channel: ch2 holds A, B, C
    for (int i = 0; i < 4; i++) clear_ch(i);
    load_ch(2, 3, 32'hA);
    cyc(4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0, 2'd0, "s_rst");
    chk("s_rst_data", out_data, 32'h0);
    chk("s_rst_ch", 32'(out_ch), 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 4'h4, 1'b0, 32'h0, 2'd0, "s0");
    cyc(4'hF, 1'b1, 1'b0, 4'h4, 1'b0, 32'h0, 2'd0, "s1");
    cyc(4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 32'hA, 2'd2, "s2");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'hB, 2'd2, "s3");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'hC, 2'd2, "s4");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0, "s5");

    // backpressure on ch0, then release
    clear_ch(2);
    load_ch(0, 5, 32'hE000_0000);
    cyc(4'hF, 1'b0, 1'b0, 4'h1, 1'b0, 32'h0,         2'd0, "b0");
    cyc(4'hF, 1'b0, 1'b0, 4'h1, 1'b0, 32'h0,         2'd0, "b1");
    cyc(4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 32'hE000_0000, 2'd0, "b2");
    cyc(4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 32'hE000_0000, 2'd0, "b3");
    cyc(4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 32'hE000_0000, 2'd0, "b4");
    chk("b_count", 32'(dut.count_q), 32'd3);
    cyc(4'hF, 1'b0, 1'b0, 4'h0, 1'b1, 32'hE000_0000, 2'd0, "b5");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'hE000_0000, 2'd0, "b6");
    cyc(4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 32'hE000_0001, 2'd0, "b7");
    cyc(4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 32'hE000_0002, 2'd0, "b8");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'hE000_0003, 2'd0, "b9");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 32'hE000_0004, 2'd0, "b10");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0,         2'd0, "b11");

    // reset the cycle after a ch1 pop with two words buffered
    load_ch(1, 4, 32'hF000_0000);
    cyc(4'hF, 1'b0, 1'b0, 4'h2, 1'b0, 32'h0,         2'd0, "m0");
    cyc(4'hF, 1'b0, 1'b0, 4'h2, 1'b0, 32'h0,         2'd0, "m1");
    cyc(4'hF, 1'b0, 1'b0, 4'h2, 1'b1, 32'hF000_0000, 2'd1, "m2");
    cyc(4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 32'hF000_0000, 2'd1, "m3");
    clear_ch(1);
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0, "m4");
    chk("m_count", 32'(dut.count_q), 32'd0);
    chk("m_data", out_data, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0, "m5");
    cyc(4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0, "m6");

    chk("no_illegal_pop", 32'(bad_pop), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
